// File: rtl/packet_length_checker_if.sv
// Beat stream into the length checker, plus the checker's registered status and counters.
// The master drives beats and clear; the slave (checker) drives flags, length and counters.
interface packet_length_checker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 3,
    parameter int CNT_WIDTH  = 4
) ();
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] packet_data_in;
    logic                  start_of_packet;
    logic                  end_of_packet;
    logic                  clear_counters;

    logic                  in_packet;
    logic                  packet_valid_flag;
    logic                  packet_error_flag;
    logic [2:0]            error_code;
    logic [LEN_WIDTH-1:0]  packet_length;
    logic [CNT_WIDTH-1:0]  packet_valid_counter;
    logic [CNT_WIDTH-1:0]  packet_error_counter;

    modport master (
        output data_valid, packet_data_in, start_of_packet, end_of_packet, clear_counters,
        input  in_packet, packet_valid_flag, packet_error_flag, error_code,
               packet_length, packet_valid_counter, packet_error_counter
    );

    modport slave (
        input  data_valid, packet_data_in, start_of_packet, end_of_packet, clear_counters,
        output in_packet, packet_valid_flag, packet_error_flag, error_code,
               packet_length, packet_valid_counter, packet_error_counter
    );
endinterface

// File: rtl/packet_length_checker.sv
// Checks each packet's beat count against [MIN_WORDS, MAX_WORDS] and classifies violations.
// Latency: 1 cycle from beat to flags/length/counters; no backpressure, every valid beat is consumed.
module packet_length_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int MIN_WORDS  = 5,
    parameter int MAX_WORDS  = 5,
    parameter int CNT_WIDTH  = 4,
    parameter int LEN_WIDTH  = $clog2(MAX_WORDS + 2)
) (
    input  logic                       clk,
    input  logic                       rst,
    packet_length_checker_if.slave     i_pkt
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_SHORT   = 3'd1;
    localparam logic [2:0] E_LONG    = 3'd2;
    localparam logic [2:0] E_ORPHAN  = 3'd3;
    localparam logic [2:0] E_RESTART = 3'd4;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_MIN = LEN_WIDTH'(MIN_WORDS);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_WORDS);
    localparam logic [LEN_WIDTH-1:0] LEN_SAT = LEN_WIDTH'(MAX_WORDS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [LEN_WIDTH-1:0]  w_cnt_nxt;
    logic [LEN_WIDTH-1:0]  w_cnt_inc;
    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_close;
    logic                  w_vld_evt;
    logic                  w_err_evt;
    logic [2:0]            w_code;

    logic                  r_vld_flag;
    logic                  r_err_flag;
    logic [2:0]            r_err_code;
    logic [LEN_WIDTH-1:0]  r_pkt_len;
    logic [CNT_WIDTH-1:0]  r_vld_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;

    logic                  w_unused_data;
    assign w_unused_data = ^i_pkt.packet_data_in;

    // Overlength packets pin at MAX_WORDS+1 so the count never wraps into the legal window.
    assign w_cnt_inc = (r_cnt >= LEN_SAT) ? LEN_SAT : r_cnt + LEN_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_close     = 1'b0;
        w_len       = r_cnt;
        w_vld_evt   = 1'b0;
        w_err_evt   = 1'b0;
        w_code      = E_NONE;

        if (i_pkt.data_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (i_pkt.start_of_packet && i_pkt.end_of_packet) begin
                        w_close = 1'b1;
                        w_len   = LEN_ONE;
                    end else if (i_pkt.start_of_packet) begin
                        w_state_nxt = S_IN_PKT;
                        w_cnt_nxt   = LEN_ONE;
                    end else if (i_pkt.end_of_packet) begin
                        w_err_evt = 1'b1;
                        w_code    = E_ORPHAN;
                        w_len     = '0;
                    end
                end
                S_IN_PKT: begin
                    if (i_pkt.start_of_packet) begin
                        // The abandoned packet is reported; a 1-beat SOP&EOP replacement is dropped.
                        w_err_evt = 1'b1;
                        w_code    = E_RESTART;
                        w_len     = r_cnt;
                        if (i_pkt.end_of_packet) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = LEN_ONE;
                        end
                    end else if (i_pkt.end_of_packet) begin
                        w_close     = 1'b1;
                        w_len       = w_cnt_inc;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (w_close) begin
            if (w_len < LEN_MIN) begin
                w_err_evt = 1'b1;
                w_code    = E_SHORT;
            end else if (w_len > LEN_MAX) begin
                w_err_evt = 1'b1;
                w_code    = E_LONG;
            end else begin
                w_vld_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_flag <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_code <= E_NONE;
            r_pkt_len  <= '0;
            r_vld_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_vld_flag <= w_vld_evt;
            r_err_flag <= w_err_evt;
            r_err_code <= w_err_evt ? w_code : E_NONE;
            if (w_vld_evt || w_err_evt) begin
                r_pkt_len <= w_len;
            end

            // A clear coinciding with an event keeps that event: the counter lands on 1.
            if (i_pkt.clear_counters) begin
                r_vld_cnt <= {{(CNT_WIDTH-1){1'b0}}, w_vld_evt};
                r_err_cnt <= {{(CNT_WIDTH-1){1'b0}}, w_err_evt};
            end else begin
                if (w_vld_evt && (r_vld_cnt != CNT_MAX)) begin
                    r_vld_cnt <= r_vld_cnt + CNT_WIDTH'(1);
                end
                if (w_err_evt && (r_err_cnt != CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign i_pkt.in_packet            = (r_state == S_IN_PKT);
    assign i_pkt.packet_valid_flag    = r_vld_flag;
    assign i_pkt.packet_error_flag    = r_err_flag;
    assign i_pkt.error_code           = r_err_code;
    assign i_pkt.packet_length        = r_pkt_len;
    assign i_pkt.packet_valid_counter = r_vld_cnt;
    assign i_pkt.packet_error_counter = r_err_cnt;

endmodule
